// File: rtl/bus_device_port.sv
// Bus device port: a TX FIFO toward the bus arbiter and an address-filtered RX FIFO toward the local consumer.
// Latency: a word written on one edge shows up on pndng/D_pop (TX) or rx_valid/rx_data (RX) after that edge.
// Backpressure: tx_ready drops at TX full. An addressed push that arrives while RX is full and not draining is dropped and counted.

// Generic show-ahead FIFO. The caller guards the enables; occupancy tells full from empty.
// Latency: a write is visible at the head on the next cycle.
// Backpressure: none internally; wr_en must not be raised when the FIFO is full and not being read.
module bus_device_port_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [width-1:0]             wr_dat,
  input  logic                         rd_en,
  output logic [width-1:0]             rd_dat,
  output logic [$clog2(depth+1)-1:0]   count
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because depth is a power of two.
  // The count is the sole full/empty indicator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale contents are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  // Show-ahead head word. It reads as zero while empty, so it is also zero throughout reset.
  assign rd_dat = (count != '0) ? mem[rd_ptr] : '0;
endmodule

module bus_device_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [pckg_sz-1:0]         tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic [7:0]                 rx_drop_cnt
);
  localparam int CW = $clog2(depth+1);
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic          tx_wr;
  logic          tx_rd;
  logic [CW-1:0] rx_count;
  logic [7:0]    dst;
  logic          rx_hit;
  logic          rx_full;
  logic          rx_rd;
  logic          rx_wr;
  logic          rx_drop;

  // TX side. A full FIFO refuses writes even when a pop happens in the same cycle,
  // which keeps tx_ready independent of the bus pop.
  assign tx_ready = (tx_count != FULL);
  assign pndng    = (tx_count != '0);
  assign tx_wr    = tx_valid && tx_ready;
  assign tx_rd    = pop && pndng;

  bus_device_port_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (tx_wr),
    .wr_dat (tx_data),
    .rd_en  (tx_rd),
    .rd_dat (D_pop),
    .count  (tx_count)
  );

  // RX side. The destination filter runs first. A full FIFO still accepts a push
  // when the consumer drains a word in the same cycle.
  assign dst      = D_push[pckg_sz-1 -: 8];
  assign rx_hit   = push && ((dst == id) || (dst == broadcast));
  assign rx_valid = (rx_count != '0);
  assign rx_full  = (rx_count == FULL);
  assign rx_rd    = rx_valid && rx_ready;
  assign rx_wr    = rx_hit && (!rx_full || rx_rd);
  assign rx_drop  = rx_hit && rx_full && !rx_rd;

  bus_device_port_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (rx_wr),
    .wr_dat (D_push),
    .rd_en  (rx_rd),
    .rd_dat (rx_data),
    .count  (rx_count)
  );

  // Count addressed packets lost to a full RX FIFO. The counter saturates at 255 rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_drop_cnt <= '0;
    end else if (rx_drop && (rx_drop_cnt != 8'hFF)) begin
      rx_drop_cnt <= rx_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bus_device_port.sv
module tb_bus_device_port;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  tx_count;
  logic [7:0]  rx_drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  int m_drop = 0;

  bus_device_port #(.pckg_sz(16), .depth(DEPTH), .id(8'd2), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state();
    chk("tx_count", {28'd0, tx_count}, tx_q.size());
    chk("pndng", {31'd0, pndng}, (tx_q.size() != 0));
    chk("tx_ready", {31'd0, tx_ready}, (tx_q.size() != DEPTH));
    chk("rx_valid", {31'd0, rx_valid}, (rx_q.size() != 0));
    chk("rx_drop_cnt", {24'd0, rx_drop_cnt}, m_drop);
    if (tx_q.size() != 0) chk("d_pop_show_ahead", {16'd0, D_pop}, {16'd0, tx_q[0]});
    if (rx_q.size() != 0) chk("rx_data_show_ahead", {16'd0, rx_data}, {16'd0, rx_q[0]});
  endtask

  // One clock of stimulus on both paths. The scoreboard is updated from the model, and popped words are compared as they leave.
  task automatic cyc(input bit w, input logic [15:0] wd, input bit p,
                     input bit ps, input logic [15:0] pd, input bit rr, output bit w_ok);
    bit p_ok, r_ok, hit, rx_full;
    logic [15:0] exp;
    w_ok    = w && (tx_q.size() != DEPTH);
    p_ok    = p && (tx_q.size() != 0);
    r_ok    = rr && (rx_q.size() != 0);
    rx_full = (rx_q.size() == DEPTH);
    hit     = ps && (pd[15:8] == 8'h02 || pd[15:8] == 8'hFF);
    if (p_ok) begin
      exp = tx_q.pop_front();
      chk("d_pop_at_pop", {16'd0, D_pop}, {16'd0, exp});
    end
    if (r_ok) begin
      exp = rx_q.pop_front();
      chk("rx_data_at_pop", {16'd0, rx_data}, {16'd0, exp});
    end
    if (hit) begin
      if (!rx_full || r_ok) rx_q.push_back(pd);
      else if (m_drop != 255) m_drop++;
    end
    if (w_ok) tx_q.push_back(wd);
    tx_valid = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_ready = rr;
    tick();
    tx_valid = 0; pop = 0; push = 0; rx_ready = 0;
    chk_state();
  endtask

  initial begin
    bit ok;
    int sent;
    reset = 0; tx_valid = 0; tx_data = '0; pop = 0; push = 0; D_push = '0; rx_ready = 0;
    #1;
    chk("rst_pndng", {31'd0, pndng}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 1);
    chk("rst_tx_count", {28'd0, tx_count}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_drop", {24'd0, rx_drop_cnt}, 0);
    chk("rst_d_pop", {16'd0, D_pop}, 0);
    chk("rst_rx_data", {16'd0, rx_data}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    tick();

    // Two words in, then popped in order
    cyc(1, 16'h0A11, 0, 0, 0, 0, ok);
    chk("first_d_pop", {16'd0, D_pop}, 32'h0A11);
    cyc(1, 16'h0B22, 0, 0, 0, 0, ok);
    cyc(0, 0, 1, 0, 0, 0, ok);
    chk("second_d_pop", {16'd0, D_pop}, 32'h0B22);
    cyc(0, 0, 1, 0, 0, 0, ok);
    chk("tx_empty_count", {28'd0, tx_count}, 0);
    cyc(0, 0, 1, 0, 0, 1, ok);  // pop / rx_ready while empty are ignored

    // Fill TX, attempt a ninth write, then pop and write in the same cycle while full
    for (int i = 0; i < 8; i++) cyc(1, 16'h1000 + 16'(i), 0, 0, 0, 0, ok);
    chk("tx_full_ready", {31'd0, tx_ready}, 0);
    cyc(1, 16'hDEAD, 0, 0, 0, 0, ok);
    cyc(1, 16'hBEEF, 1, 0, 0, 0, ok);
    chk("full_pop_wr_count", {28'd0, tx_count}, 7);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0, 0, ok);

    // RX address filter: own id, foreign id, broadcast
    cyc(0, 0, 0, 1, 16'h02AA, 0, ok);
    chk("rx_own", {16'd0, rx_data}, 32'h02AA);
    cyc(0, 0, 0, 1, 16'h03BB, 0, ok);
    cyc(0, 0, 0, 1, 16'hFFCC, 0, ok);
    cyc(0, 0, 0, 0, 0, 1, ok);
    cyc(0, 0, 0, 0, 0, 1, ok);

    // RX overflow, drop counting with saturation, and a full push accepted while draining
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 16'h0200 + 16'(i), 0, ok);
    chk("rx_drop_two", {24'd0, rx_drop_cnt}, 2);
    cyc(0, 0, 0, 1, 16'h0277, 1, ok);
    chk("rx_drain_push_nodrop", {24'd0, rx_drop_cnt}, 2);
    for (int i = 0; i < 255; i++) cyc(0, 0, 0, 1, 16'hFF00 + 16'(i), 0, ok);
    chk("rx_drop_sat", {24'd0, rx_drop_cnt}, 255);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, ok);

    // Simultaneous push and pop on TX and RX, then async reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, 16'h5500 + 16'(i), 0, (i < 2), 16'h0260 + 16'(i), 0, ok);
    cyc(1, 16'h55AA, 1, 1, 16'hFF61, 1, ok);
    #3 reset = 0;
    #1;
    chk("arst_pndng", {31'd0, pndng}, 0);
    chk("arst_tx_count", {28'd0, tx_count}, 0);
    chk("arst_rx_valid", {31'd0, rx_valid}, 0);
    chk("arst_drop", {24'd0, rx_drop_cnt}, 0);
    chk("arst_d_pop", {16'd0, D_pop}, 0);
    chk("arst_tx_ready", {31'd0, tx_ready}, 1);
    tx_valid = 1; tx_data = 16'h0123; push = 1; D_push = 16'h0211; pop = 1; rx_ready = 1;
    tick();
    chk("arst_hold_count", {28'd0, tx_count}, 0);
    chk("arst_hold_rx", {31'd0, rx_valid}, 0);
    tx_valid = 0; push = 0; pop = 0; rx_ready = 0;
    tx_q.delete(); rx_q.delete(); m_drop = 0;
    @(negedge clk) reset = 1;
    tick();
    chk_state();

    // Stream 20 packets with random pop gaps across the pointer wrap
    sent = 0;
    for (int c = 0; c < 600 && (sent < 20 || tx_q.size() != 0); c++) begin
      cyc((sent < 20) && ($urandom_range(0, 3) != 0), 16'hC000 + 16'(sent),
          ($urandom_range(0, 2) == 0), 0, 0, 0, ok);
      if (ok) sent++;
    end
    chk("stream_sent", sent, 20);
    chk("stream_drained", tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_device_port.md
BUS_DEVICE_PORT -- requirements
Module: bus_device_port

Interface
REQ-001 SHALL have parameter pckg_sz, default 16, packet width in bits.
REQ-002 SHALL have parameter depth, default 8, entries in each of the TX and RX FIFOs (power of 2, >=2).
REQ-003 SHALL have parameter id, default 0, this device's 8-bit destination address.
REQ-004 SHALL have parameter broadcast, default 8'hFF, broadcast destination address.
REQ-005 SHALL have port clk, input, 1, single clock (all logic on rising edge).
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port tx_data, input, pckg_sz, packet from local producer; bits [pckg_sz-1 -: 8] hold destination ID.
REQ-008 SHALL have port tx_valid, input, 1, local producer offers tx_data.
REQ-009 SHALL have port tx_ready, output, 1, TX FIFO can accept (not full).
REQ-010 SHALL have port pndng, output, 1, TX FIFO non-empty, presented to bus arbiter.
REQ-011 SHALL have port D_pop, output, pckg_sz, TX FIFO head word, presented to bus.
REQ-012 SHALL have port pop, input, 1, bus removes D_pop this cycle.
REQ-013 SHALL have port push, input, 1, bus delivers D_push this cycle.
REQ-014 SHALL have port D_push, input, pckg_sz, packet delivered by bus.
REQ-015 SHALL have port rx_data, output, pckg_sz, RX FIFO head to local consumer.
REQ-016 SHALL have port rx_valid, output, 1, RX FIFO non-empty.
REQ-017 SHALL have port rx_ready, input, 1, local consumer accepts rx_data.
REQ-018 SHALL have port tx_count, output, $clog2(depth+1), TX FIFO occupancy.
REQ-019 SHALL have port rx_drop_cnt, output, 8, count of addressed packets dropped for RX full.

Function
REQ-020 SHALL write tx_data into TX FIFO on a clock edge where tx_valid && tx_ready; tx_ready = (tx_count != depth), combinational from state only.
REQ-021 SHALL drive pndng = (tx_count != 0) and D_pop = TX head (show-ahead), both from registered state, no combinational path from pop/push.
REQ-022 SHALL, on pop && pndng, advance TX read pointer; pop with pndng=0 SHALL be ignored (no pointer/count change).
REQ-023 SHALL handle simultaneous TX write and pop: count unchanged, both pointers advance; at full, write blocked (tx_ready=0) even if pop same cycle.
REQ-024 SHALL make a TX write visible on pndng/D_pop the cycle after the write edge (1-cycle latency, including write into empty FIFO).
REQ-025 SHALL accept push when D_push[pckg_sz-1 -: 8] == id or == broadcast; other destinations SHALL be discarded silently.
REQ-026 SHALL store an accepted push into RX FIFO if RX not full, or if full and rx_valid && rx_ready the same cycle (pop frees slot).
REQ-027 SHALL drop an accepted push when RX full and not draining, increment rx_drop_cnt, saturating at 255.
REQ-028 SHALL drive rx_valid = RX non-empty, rx_data = RX head (show-ahead); stored packet visible the cycle after push.
REQ-029 SHALL pop RX on rx_valid && rx_ready; rx_ready with rx_valid=0 ignored.
REQ-030 SHALL wrap FIFO pointers modulo depth; full/empty distinguished by occupancy counters, never pointer equality alone.
REQ-031 SHALL keep TX and RX paths fully independent; push and pop in the same cycle both processed.

Reset
REQ-032 SHALL, while reset=0 (asynchronous), clear pointers and counters: pndng=0, tx_ready=1, tx_count=0, rx_valid=0, rx_drop_cnt=0; D_pop/rx_data SHALL be 0.
REQ-033 SHALL discard all FIFO contents on reset assertion mid-operation; push/pop/tx_valid during reset ignored.
REQ-034 SHALL resume on first rising clk after reset deasserts.

Verification
REQ-035 Write 16'h0A11, 16'h0B22 via tx -> pndng=1 next cycle, D_pop=16'h0A11; pop -> D_pop=16'h0B22; pop -> pndng=0, tx_count=0.
REQ-036 Write 8 words, no pop -> tx_ready=0, tx_count=8; 9th tx_valid ignored; pop+tx_valid same cycle at full -> count 7, nothing written.
REQ-037 id=2: push D_push=16'h02AA -> rx_valid=1, rx_data=16'h02AA; push 16'h03BB -> ignored; push 16'hFFCC -> stored.
REQ-038 id=2, rx_ready=0: push 10 addressed packets -> 8 stored, rx_drop_cnt=2; full + push + rx_ready same cycle -> stored, no drop.
REQ-039 Fill TX with 3 and RX with 2 entries, assert reset=0 mid-cycle -> pndng, rx_valid, counts go 0 immediately without clock edge.
REQ-040 Stream 20 packets through TX with random pop gaps -> D_pop sequence equals input order across pointer wrap.
